// File: rtl/clock_display_pkg.sv
// rtl/clock_display_pkg.sv - shared constants, encodings and BCD split helpers for clock_display
package clock_display_pkg;

  // Digit index: which of the six display positions is being driven
  localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
  localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
  localparam logic [2:0] DIG_HOUR_TENS = 3'd5;
  localparam logic [2:0] DIG_LAST      = DIG_HOUR_TENS;

  // Field selected for blinking while the time is being adjusted
  typedef enum logic [1:0] {
    BLINK_NONE = 2'd0,
    BLINK_SEC  = 2'd1,
    BLINK_MIN  = 2'd2,
    BLINK_HOUR = 2'd3
  } blink_sel_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Largest legal value of each field; anything above shows a dash
  localparam logic [5:0] SEC_MIN_MAX = 6'd59;
  localparam logic [5:0] HOUR_MAX    = 6'd23;

  // Tens digit of a 6-bit value by a compare ladder (values never exceed 63)
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd60)      return 4'd6;
    else if (v >= 6'd50) return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  // Ones digit: the remainder always fits in 4 bits, so modulo-16 arithmetic is exact
  function automatic logic [3:0] ones_of(input logic [5:0] v, input logic [3:0] tens);
    return v[3:0] - (tens * 4'd10);
  endfunction

endpackage

// File: rtl/clock_display_seg7_decode.sv
// rtl/clock_display_seg7_decode.sv - BCD digit plus dash flag to active-low 7-segment pattern
module seg7_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  output logic [6:0] seg
);

  // Glyph lookup; the dash flag overrides the digit, non-BCD codes stay dark
  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/clock_display.sv
// rtl/clock_display.sv - six-digit multiplexed hh.mm.ss display driver with field blinking
module clock_display
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [5:0] hour,
  input  logic [1:0] blink_sel,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [5:0]    snap_sec_q, snap_sec_d;
  logic [5:0]    snap_min_q, snap_min_d;
  logic [5:0]    snap_hour_q, snap_hour_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic          presc_tc;
  logic          frame_end;
  logic [5:0]    field_v;
  logic [5:0]    field_max;
  logic          use_tens;
  blink_sel_e    field_sel;
  logic [3:0]    tens;
  logic [3:0]    ones;
  logic [3:0]    digit_nib;
  logic          invalid;
  logic          blank;
  logic [6:0]    glyph;

  // Scan prescaler, digit index, frame snapshot and blink phase next-state
  always_comb begin
    presc_tc    = (presc_q == PRESC_MAX);
    frame_end   = presc_tc && (digit_q == DIG_LAST);
    presc_d     = presc_tc ? '0 : presc_q + 1'b1;
    digit_d     = digit_q;
    snap_sec_d  = snap_sec_q;
    snap_min_d  = snap_min_q;
    snap_hour_d = snap_hour_q;
    frame_d     = frame_q;
    phase_d     = phase_q;
    if (presc_tc) begin
      digit_d = (digit_q == DIG_LAST) ? DIG_SEC_ONES : digit_q + 3'd1;
    end
    if (frame_end) begin
      snap_sec_d  = sec;
      snap_min_d  = min;
      snap_hour_d = hour;
      if (frame_q == FRAME_MAX) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Pick the snapshot field, its limit and tens/ones position for the current digit
  always_comb begin
    field_v   = snap_sec_q;
    field_max = SEC_MIN_MAX;
    field_sel = BLINK_SEC;
    use_tens  = 1'b0;
    case (digit_q)
      DIG_SEC_ONES:  begin field_v = snap_sec_q;  field_max = SEC_MIN_MAX; field_sel = BLINK_SEC;  use_tens = 1'b0; end
      DIG_SEC_TENS:  begin field_v = snap_sec_q;  field_max = SEC_MIN_MAX; field_sel = BLINK_SEC;  use_tens = 1'b1; end
      DIG_MIN_ONES:  begin field_v = snap_min_q;  field_max = SEC_MIN_MAX; field_sel = BLINK_MIN;  use_tens = 1'b0; end
      DIG_MIN_TENS:  begin field_v = snap_min_q;  field_max = SEC_MIN_MAX; field_sel = BLINK_MIN;  use_tens = 1'b1; end
      DIG_HOUR_ONES: begin field_v = snap_hour_q; field_max = HOUR_MAX;    field_sel = BLINK_HOUR; use_tens = 1'b0; end
      DIG_HOUR_TENS: begin field_v = snap_hour_q; field_max = HOUR_MAX;    field_sel = BLINK_HOUR; use_tens = 1'b1; end
      default:       begin field_v = snap_sec_q;  field_max = SEC_MIN_MAX; field_sel = BLINK_NONE; use_tens = 1'b0; end
    endcase
    tens      = tens_of(field_v);
    ones      = ones_of(field_v, tens);
    digit_nib = use_tens ? tens : ones;
    invalid   = (field_v > field_max);
    blank     = phase_q && (field_sel != BLINK_NONE) && (blink_sel == field_sel);
  end

  seg7_decode u_seg7_decode (
    .digit (digit_nib),
    .dash  (invalid),
    .seg   (glyph)
  );

  // Output register inputs: one digit enable, its glyph and the hh.mm.ss separators
  always_comb begin
    an_d  = ~(6'b000001 << digit_q);
    seg_d = glyph;
    dp_d  = ~((digit_q == DIG_MIN_ONES) || (digit_q == DIG_HOUR_ONES));
    if (blank) begin
      an_d  = 6'b111111;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  // State and output registers; reset darkens the display immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      digit_q     <= DIG_SEC_ONES;
      frame_q     <= '0;
      phase_q     <= 1'b0;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
      snap_hour_q <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= 6'b111111;
      dp_q        <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      frame_q     <= frame_d;
      phase_q     <= phase_d;
      snap_sec_q  <= snap_sec_d;
      snap_min_q  <= snap_min_d;
      snap_hour_q <= snap_hour_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display.sv
// tb/tb_clock_display.sv - scoreboard bench for clock_display with small scan/blink dividers
module tb_clock_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = 6 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sec, min, hour;
  logic [1:0] blink_sel;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  int s_sec = 0, s_min = 0, s_hour = 0;
  logic [13:0] exp_q[$];

  clock_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .blink_sel (blink_sel),
    .seg       (seg),
    .an        (an),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;  4: return 7'h19;
      5: return 7'h12;  6: return 7'h02;  7: return 7'h78;  8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  // Expected {an,seg,dp} after clock edge kk (counted from reset release)
  function automatic logic [13:0] model(input int kk);
    int j, d, ph, fld, v, lim;
    logic [5:0] a;
    logic [6:0] s;
    logic p;
    j   = kk - 1;
    d   = (j / SCAN_DIV) % 6;
    ph  = ((j / FRAME) / BLINK_DIV) % 2;
    fld = d / 2;
    v   = (fld == 0) ? s_sec : (fld == 1) ? s_min : s_hour;
    lim = (fld == 2) ? 23 : 59;
    if (ph == 1 && int'(blink_sel) == fld + 1) begin
      return {6'h3F, 7'h7F, 1'b1};
    end
    a = ~(6'd1 << d);
    s = (v > lim) ? 7'h3F : glyph((d % 2 == 1) ? v / 10 : v % 10);
    p = (d == 2 || d == 4) ? 1'b0 : 1'b1;
    return {a, s, p};
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
             tag, obs[13:8], obs[7:1], obs[0], expv[13:8], expv[7:1], expv[0]);
    end
  endtask

  task automatic cycle();
    int lows;
    exp_q.push_back(model(k + 1));
    @(posedge clk);
    #1;
    k++;
    check($sformatf("out_k%0d", k), {an, seg, dp}, exp_q.pop_front());
    lows = $countones(~an);
    n_cmp++;
    assert (lows <= 1) else begin
      n_bad++;
      $error("FAIL an_onehot_k%0d: observed %0d low bits, expected at most 1", k, lows);
    end
    if (k % FRAME == 0) begin
      s_sec  = int'(sec);
      s_min  = int'(min);
      s_hour = int'(hour);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic restart_model();
    k = 0; s_sec = 0; s_min = 0; s_hour = 0;
  endtask

  initial begin
    sec = 6'd45; min = 6'd7; hour = 6'd13; blink_sel = 2'd0;

    // Reset held: display dark
    @(posedge clk); #1;
    check("reset_hold", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
    @(posedge clk); #1;
    check("reset_hold2", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});

    // Release: zero snapshot frame, then 45/07/13
    @(negedge clk); rst_n = 1'b1;
    restart_model();
    run(2 * FRAME);

    // Seconds change mid-frame only appears at the next frame
    run(10);
    sec = 6'd46;
    run(2 * FRAME - 10);

    // Out-of-range seconds and hours show dashes
    sec = 6'd60; hour = 6'd24;
    run(2 * FRAME);

    // Blink minutes for two full blink periods
    sec = 6'd45; hour = 6'd13; blink_sel = 2'd2;
    run(4 * FRAME);
    blink_sel = 2'd0;

    // Asynchronous reset in the middle of digit 3
    while (!(((k - 1) / SCAN_DIV) % 6 == 3 && (k - 1) % SCAN_DIV == 1)) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
    @(posedge clk); #1;
    check("async_reset_hold", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
    @(negedge clk); rst_n = 1'b1;
    restart_model();
    run(FRAME + 6);

    // Long random soak with occasional input and blink changes
    for (int i = 0; i < 720; i++) begin
      cycle();
      if ($urandom_range(0, 7) == 0) sec  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) min  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) hour = 6'($urandom_range(0, 31));
      if ($urandom_range(0, 31) == 0) blink_sel = 2'($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_display.md
CLOCK_DISPLAY -- requirements
Module: clock_display

Interface
REQ-001 SCAN_DIV, 1000, clk cycles each digit is held (minimum 2).
REQ-002 BLINK_DIV, 250, scan frames per blink half-period (minimum 1).
REQ-003 clk  in  1  single system clock; all state on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 sec  in  6  seconds value from the time counter, binary.
REQ-006 min  in  6  minutes value, binary.
REQ-007 hour  in  6  hours value, binary.
REQ-008 blink_sel  in  2  field blinked during adjust: 0 none, 1 sec, 2 min, 3 hour.
REQ-009 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 an  out  6  digit enables, active-low: bit0 sec ones, bit1 sec tens, bit2 min ones, bit3 min tens, bit4 hour ones, bit5 hour tens.
REQ-011 dp  out  1  decimal point, active-low.

Function
REQ-012 Prescaler shall count 0..SCAN_DIV-1 and wrap; at terminal count the digit index shall advance by one, 5 wrapping to 0.
REQ-013 sec/min/hour shall be captured into a snapshot register on the cycle the digit index wraps 5->0; one whole frame shall display one coherent snapshot.
REQ-014 Each field shall split into tens = v/10 and ones = v%10 (4-bit each); no division by a general divider.
REQ-015 sec or min > 59, or hour > 23, shall display dash (segment g only, seg=7'b0111111) on both digits of that field.
REQ-016 Digit glyphs 0-9 shall use the standard active-low 7-segment encoding; '0' = 7'b1000000, '8' = 7'b0000000.
REQ-017 seg, an, dp shall be registered; they shall reflect a new digit index exactly one clk after the index changes.
REQ-018 Exactly one an bit shall be low at any time after the first post-reset output update, except when blanked per REQ-020.
REQ-019 dp shall be low while digit 2 or digit 4 is enabled (hh.mm.ss separators), high otherwise.
REQ-020 Blink phase shall toggle every BLINK_DIV frame boundaries; while phase=1 and the current digit belongs to the field selected by blink_sel, an shall be all-high and seg all-high.
REQ-021 blink_sel shall be sampled every cycle (not snapshotted); a change to 0 shall stop blanking on the next output update.
REQ-022 Blink frame counter and phase shall keep running regardless of blink_sel.

Reset
REQ-023 While rst_n is low: an=6'b111111, seg=7'b1111111, dp=1, prescaler=0, digit index=0, frame counter=0, blink phase=0, snapshot=0.
REQ-024 Reset asserted mid-frame shall take effect immediately without waiting for a clock; after release the first output update shall occur one cycle later and show digit 0 of the zero snapshot until the first frame boundary.

Structure
REQ-025 Package clock_display_pkg shall hold digit-index constants, blink_sel encodings, the digit/dash segment constants and the field limits (59, 23).
REQ-026 A combinational sub-module seg7_decode (4-bit digit plus dash flag -> 7-bit active-low segments) shall be instantiated once on the selected digit.
REQ-027 The block shall be instantiated downstream of the time counter, driven directly by its sec/min/hour outputs.

Verification (SCAN_DIV=4, BLINK_DIV=2 for simulation)
REQ-028 Reset release, sec=45 min=07 hour=13 -> after first frame, per digit an/seg: 0 '5', 1 '4', 2 '7' dp low, 3 '0', 4 '3' dp low, 5 '1'; each held 4 cycles.
REQ-029 Change sec 45->46 mid-frame -> current frame still shows 45; next frame shows 46.
REQ-030 sec=60, hour=24 -> digits 0,1,4,5 show 7'b0111111; min digits unaffected.
REQ-031 blink_sel=2 -> digits 2,3 blanked (an all-high) for 2 frames, shown for 2 frames, repeating; other digits never blanked.
REQ-032 rst_n pulsed low mid-digit 3 -> an=6'b111111, seg=7'b1111111 asynchronously; restart at digit 0 after release.
REQ-033 Over 1000 cycles, an is never zero-hot-violating: count of low bits ≤ 1 every cycle.
